hilo_muldiv: RTL and testbench

Owns the architectural HI/LO register pair and the iterative multiply/divide engine behind the EX stage. It answers EX in both directions: it serves combinational `hi_read_data`/`lo_read_data` reads (MFHI/MFLO), and it accepts direct HI/LO writes (MTHI/MTLO). It also runs MULT/MULTU/DIV/DIVU as a 32-iteration radix-2 operation that stalls the pipeline via `md_busy`. Results are committed to HI/LO only on completion and can be cancelled by a pipeline flush.

---
 rtl/hilo_muldiv.sv | 165 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative radix-2 multiply/divide engine.
// Serves MFHI/MFLO reads, MTHI/MTLO writes, and stalls EX while busy.
module hilo_muldiv #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hilo_write_en,
   input  logic [31:0] hi_write_data,
   input  logic [31:0] lo_write_data,
   output logic [31:0] hi_read_data,
   output logic [31:0] lo_read_data,
   input  logic        md_start,
   input  logic [1:0]  md_op,
   input  logic [31:0] md_operand_1,
   input  logic [31:0] md_operand_2,
   input  logic        md_cancel,
   output logic        md_busy,
   output logic        md_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  op;
   logic        dz;
   logic        neg_res;
   logic        neg_rem;
   logic [5:0]  cnt;
   logic [63:0] acc;
   logic [63:0] mcand;
   logic [31:0] qr;
   logic [31:0] rem;

   logic        sgn;
   logic        s1;
   logic        s2;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic        dz_start;
   logic        start_ok;
   logic        commit;
   logic [32:0] rem_sh;
   logic [32:0] rem_nx;
   logic        ge;
   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rmd;

   assign hi_read_data = hi;
   assign lo_read_data = lo;

   assign sgn      = ~md_op[0];
   assign s1       = sgn & md_operand_1[31];
   assign s2       = sgn & md_operand_2[31];
   assign mag1     = s1 ? -md_operand_1 : md_operand_1;
   assign mag2     = s2 ? -md_operand_2 : md_operand_2;
   assign dz_start = md_op[1] && (md_operand_2 == 32'd0);
   assign start_ok = (state == IDLE) && md_start && !md_cancel;
   assign commit   = (state == DONE) && !md_cancel;

   // Restoring divide step: remainder stays below the divisor, so 32 bits hold it.
   assign rem_sh = {rem, qr[31]};
   assign ge     = rem_sh >= {1'b0, mcand[31:0]};
   assign rem_nx = ge ? rem_sh - {1'b0, mcand[31:0]} : rem_sh;

   assign prod = neg_res ? -acc : acc;
   assign quo  = neg_res ? -qr : qr;
   assign rmd  = neg_rem ? -rem : rem;

   always_comb begin
      state_nx = state;
      md_busy  = 1'b1;
      md_done  = 1'b0;
      unique case (state)
         IDLE: begin
            md_busy = md_start & ~md_cancel;
            if (md_start)
               state_nx = dz_start ? DONE : RUN;
         end
         RUN: begin
            if (cnt == 6'(ITER - 1))
               state_nx = DONE;
         end
         DONE: begin
            md_done  = ~md_cancel;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (md_cancel)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi      <= '0;
         lo      <= '0;
         op      <= '0;
         dz      <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         qr      <= '0;
         rem     <= '0;
      end else begin
         if (commit) begin
            if (dz) begin
               hi <= qr;
               lo <= 32'hFFFF_FFFF;
            end else if (!op[1]) begin
               hi <= prod[63:32];
               lo <= prod[31:0];
            end else begin
               hi <= rmd;
               lo <= quo;
            end
         end else if ((state == IDLE) && hilo_write_en) begin
            hi <= hi_write_data;
            lo <= lo_write_data;
         end

         if (start_ok) begin
            op      <= md_op;
            dz      <= dz_start;
            neg_res <= s1 ^ s2;
            neg_rem <= s1;
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            if (md_op[1]) begin
               mcand <= {32'd0, mag2};
               qr    <= dz_start ? md_operand_1 : mag1;
            end else begin
               mcand <= {32'd0, mag1};
               qr    <= mag2;
            end
         end else if (state == RUN) begin
            cnt <= cnt + 6'd1;
            if (!op[1]) begin
               if (qr[0])
                  acc <= acc + mcand;
               mcand <= mcand << 1;
               qr    <= qr >> 1;
            end else begin
               rem <= rem_nx[31:0];
               qr  <= {qr[30:0], ge};
            end
         end
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized and directed bench for hilo_muldiv against an arithmetic model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_hilo_muldiv;

   logic        clk;
   logic        rst_n;
   logic        hilo_write_en;
   logic [31:0] hi_write_data;
   logic [31:0] lo_write_data;
   logic [31:0] hi_read_data;
   logic [31:0] lo_read_data;
   logic        md_start;
   logic [1:0]  md_op;
   logic [31:0] md_operand_1;
   logic [31:0] md_operand_2;
   logic        md_cancel;
   logic        md_busy;
   logic        md_done;

   int nchk = 0;
   int nerr = 0;

   hilo_muldiv #(.ITER(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .hilo_write_en (hilo_write_en),
      .hi_write_data (hi_write_data),
      .lo_write_data (lo_write_data),
      .hi_read_data  (hi_read_data),
      .lo_read_data  (lo_read_data),
      .md_start      (md_start),
      .md_op         (md_op),
      .md_operand_1  (md_operand_1),
      .md_operand_2  (md_operand_2),
      .md_cancel     (md_cancel),
      .md_busy       (md_busy),
      .md_done       (md_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {HI, LO} straight from integer arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint m;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      case (op)
         2'd0: r = sa * sb;
         2'd1: r = {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0) begin
               r = {a, 32'hFFFF_FFFF};
            end else if (op == 2'd2) begin
               q = sa / sb;
               m = sa % sb;
               r = {m[31:0], q[31:0]};
            end else begin
               r = {a % b, a / b};
            end
         end
      endcase
      return r;
   endfunction

   // Issue one operation; reports latency to md_done, busy coverage, and result.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output bit busy_ok, output logic [31:0] h,
                         output logic [31:0] l);
      @(negedge clk);
      md_start     = 1'b1;
      md_op        = op;
      md_operand_1 = a;
      md_operand_2 = b;
      #1;
      busy_ok = md_busy;
      lat     = -1;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(negedge clk);
         md_start = 1'b0;
         #1;
         if (!md_busy) busy_ok = 1'b0;
         if (md_done) lat = k;
      end
      @(negedge clk);
      #1;
      h = hi_read_data;
      l = lo_read_data;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hilo_write_en = 1'b0;
      hi_write_data = '0;
      lo_write_data = '0;
      md_start = 1'b0;
      md_op = '0;
      md_operand_1 = '0;
      md_operand_2 = '0;
      md_cancel = 1'b0;
      #12;
      nchk++;
      if (hi_read_data !== 32'd0 || lo_read_data !== 32'd0 ||
          md_busy !== 1'b0 || md_done !== 1'b0) begin
         nerr++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b want 0/0/0/0",
                  hi_read_data, lo_read_data, md_busy, md_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_direct_write();
      logic [31:0] h;
      logic [31:0] l;
      @(negedge clk);
      hilo_write_en = 1'b1;
      hi_write_data = 32'h1234_5678;
      lo_write_data = 32'h9ABC_DEF0;
      #1;
      nchk++;
      if (hi_read_data !== 32'd0) begin
         nerr++;
         $display("FAIL write_no_bypass: hi=%h want 00000000", hi_read_data);
      end
      @(negedge clk);
      hilo_write_en = 1'b0;
      #1;
      nchk++;
      if (hi_read_data !== 32'h1234_5678 || lo_read_data !== 32'h9ABC_DEF0) begin
         nerr++;
         $display("FAIL write_vis: hi=%h lo=%h want 12345678 9abcdef0",
                  hi_read_data, lo_read_data);
      end
      // Start with a simultaneous write; a write during RUN must be dropped.
      @(negedge clk);
      md_start = 1'b1;
      md_op = 2'd1;
      md_operand_1 = 32'd6;
      md_operand_2 = 32'd7;
      hilo_write_en = 1'b1;
      hi_write_data = 32'hAAAA_0001;
      lo_write_data = 32'hBBBB_0002;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         md_start = 1'b0;
         hilo_write_en = (k == 5);
         hi_write_data = 32'hDEAD_BEEF;
         lo_write_data = 32'hDEAD_BEEF;
         #1;
         if (k == 6) begin
            h = hi_read_data;
            l = lo_read_data;
         end
      end
      hilo_write_en = 1'b0;
      nchk++;
      if (h !== 32'hAAAA_0001 || l !== 32'hBBBB_0002) begin
         nerr++;
         $display("FAIL write_in_run: hi=%h lo=%h want aaaa0001 bbbb0002", h, l);
      end
      nchk++;
      if (hi_read_data !== 32'd0 || lo_read_data !== 32'd42) begin
         nerr++;
         $display("FAIL write_then_commit: hi=%h lo=%h want 0 0000002a",
                  hi_read_data, lo_read_data);
      end
   endtask

   task automatic test_directed();
      logic [1:0]  ops [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
      logic [31:0] as  [7] = '{-32'sd3, 32'hFFFF_FFFF, -32'sd7, 32'd100,
                               32'h8000_0000, 32'd5, -32'sd9};
      logic [31:0] bs  [7] = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'd7,
                               32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [63:0] exp [7] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFE_0000_0001,
                               64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                               64'h0000_0000_8000_0000, 64'h0000_0005_FFFF_FFFF,
                               64'hFFFF_FFF7_FFFF_FFFF};
      int lat;
      bit bok;
      logic [31:0] h;
      logic [31:0] l;
      int want;
      for (int i = 0; i < 7; i++) begin
         run_op(ops[i], as[i], bs[i], lat, bok, h, l);
         want = (ops[i][1] && bs[i] == 0) ? 1 : 33;
         nchk++;
         if (lat !== want || !bok) begin
            nerr++;
            $display("FAIL dir%0d_timing: done_at=%0d busy_ok=%0d want %0d/1",
                     i, lat, bok, want);
         end
         nchk++;
         if ({h, l} !== exp[i]) begin
            nerr++;
            $display("FAIL dir%0d_result: got %h want %h", i, {h, l}, exp[i]);
         end
      end
      nchk++;
      if (md_busy !== 1'b0 || md_done !== 1'b0) begin
         nerr++;
         $display("FAIL idle_after: busy=%b done=%b want 0/0", md_busy, md_done);
      end
   endtask

   task automatic test_random();
      int lat;
      bit bok;
      logic [31:0] h;
      logic [31:0] l;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] e;
      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
         e = model(op, a, b);
         run_op(op, a, b, lat, bok, h, l);
         nchk++;
         if ({h, l} !== e || !bok ||
             lat !== ((op[1] && b == 0) ? 1 : 33)) begin
            nerr++;
            $display("FAIL rand%0d op=%0d a=%h b=%h: got %h lat=%0d want %h",
                     i, op, a, b, {h, l}, lat, e);
         end
      end
   endtask

   task automatic test_cancel();
      logic [31:0] h0;
      logic [31:0] l0;
      int lat;
      bit bok;
      logic [31:0] h;
      logic [31:0] l;
      h0 = hi_read_data;
      l0 = lo_read_data;
      @(negedge clk);
      md_start = 1'b1;
      md_op = 2'd0;
      md_operand_1 = 32'd11;
      md_operand_2 = 32'd13;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         md_start = 1'b0;
         md_cancel = (k == 10);
      end
      md_cancel = 1'b0;
      #1;
      nchk++;
      if (md_busy !== 1'b0 || hi_read_data !== h0 || lo_read_data !== l0) begin
         nerr++;
         $display("FAIL cancel_run: busy=%b hi=%h lo=%h want 0 %h %h",
                  md_busy, hi_read_data, lo_read_data, h0, l0);
      end
      run_op(2'd3, 32'd50, 32'd8, lat, bok, h, l);
      nchk++;
      if (lat !== 33 || {h, l} !== 64'h0000_0002_0000_0006) begin
         nerr++;
         $display("FAIL cancel_restart: lat=%0d got %h want 33 0000000200000006",
                  lat, {h, l});
      end
      // Cancel while in DONE: commit is suppressed.
      @(negedge clk);
      md_start = 1'b1;
      md_op = 2'd1;
      md_operand_1 = 32'd3;
      md_operand_2 = 32'd3;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         md_start = 1'b0;
         md_cancel = (k == 33);
      end
      md_cancel = 1'b0;
      #1;
      nchk++;
      if (md_busy !== 1'b0 || hi_read_data !== 32'd2 || lo_read_data !== 32'd6) begin
         nerr++;
         $display("FAIL cancel_done: busy=%b hi=%h lo=%h want 0 2 6",
                  md_busy, hi_read_data, lo_read_data);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit bok;
      logic [31:0] h;
      logic [31:0] l;
      @(negedge clk);
      md_start = 1'b1;
      md_op = 2'd2;
      md_operand_1 = 32'd1000;
      md_operand_2 = 32'd3;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         md_start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      nchk++;
      if (hi_read_data !== 32'd0 || lo_read_data !== 32'd0 || md_busy !== 1'b0) begin
         nerr++;
         $display("FAIL reset_mid: hi=%h lo=%h busy=%b want 0 0 0",
                  hi_read_data, lo_read_data, md_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(2'd2, -32'sd100, 32'd7, lat, bok, h, l);
      nchk++;
      if (lat !== 33 || {h, l} !== model(2'd2, -32'sd100, 32'd7)) begin
         nerr++;
         $display("FAIL reset_restart: lat=%0d got %h", lat, {h, l});
      end
   endtask

   task automatic test_back_to_back();
      int d1;
      int d2;
      logic [63:0] r1;
      d1 = -1;
      d2 = -1;
      r1 = '0;
      // md_start held high: ignored while busy, re-accepted at T+34.
      @(negedge clk);
      md_start = 1'b1;
      md_op = 2'd0;
      md_operand_1 = 32'd1234;
      md_operand_2 = -32'sd56;
      for (int k = 1; k <= 70 && d2 < 0; k++) begin
         @(negedge clk);
         if (k == 5) begin
            md_op = 2'd3;
            md_operand_1 = 32'd999;
            md_operand_2 = 32'd10;
         end
         if (k == 35) md_start = 1'b0;
         #1;
         if (k == 34) r1 = {hi_read_data, lo_read_data};
         if (md_done && d1 < 0) d1 = k;
         else if (md_done) d2 = k;
      end
      md_start = 1'b0;
      nchk++;
      if (d1 !== 33 || d2 !== 67) begin
         nerr++;
         $display("FAIL b2b_timing: done at %0d,%0d want 33,67", d1, d2);
      end
      nchk++;
      if (r1 !== model(2'd0, 32'd1234, -32'sd56)) begin
         nerr++;
         $display("FAIL b2b_first: got %h want %h", r1,
                  model(2'd0, 32'd1234, -32'sd56));
      end
      @(negedge clk);
      #1;
      nchk++;
      if ({hi_read_data, lo_read_data} !== 64'h0000_0009_0000_0063) begin
         nerr++;
         $display("FAIL b2b_second: got %h want 0000000900000063",
                  {hi_read_data, lo_read_data});
      end
   endtask

   initial begin
      test_reset();
      test_direct_write();
      test_directed();
      test_random();
      test_cancel();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end

endmodule
